// File: rtl/store_rmw_unit.sv
// store_rmw_unit: writes pipeline stores (word/half/byte) to a word-wide
// data memory without byte enables, using read-modify-write for sub-word
// stores. Stalls the pipeline through req_ready.
//
// Ports:
//   clk, rst (async, active-low)
//   req_valid/req_ready, req_addr, req_wdata, ByteControl : store request
//   done : one-cycle pulse when a store completes
//   err  : one-cycle pulse when a misaligned store is dropped
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack : memory port
//
// Optional feature macro: MISALIGN_TRAP_EN (drop misaligned half/word
// stores and pulse err). Without it err is constant 0 and misaligned
// addresses are aligned down.
module store_rmw_unit #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [3:0]        ByteControl,
   output logic              done,
   output logic              err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE
   } state_t;

   state_t            r_state, w_state;
   logic              r_mem_req, w_mem_req;
   logic              r_mem_we, w_mem_we;
   logic [ADDR_W-1:0] r_mem_addr, w_mem_addr;
   logic [31:0]       r_mem_wdata, w_mem_wdata;
   logic              r_done, w_done;
   logic              r_err, w_err;
   logic [15:0]       r_data, w_data;
   logic              r_half, w_half;
   logic [1:0]        r_lane, w_lane;

   logic              w_is_byte;
   logic              w_is_half;
   logic              w_misalign;
   logic [31:0]       w_merged;

   // Unknown ByteControl codes fall through to a word store.
   assign w_is_byte = (ByteControl == 4'b0001);
   assign w_is_half = (ByteControl == 4'b0011);

`ifdef MISALIGN_TRAP_EN
   assign w_misalign = (w_is_half && req_addr[0]) ||
                       (!w_is_byte && !w_is_half &&
                        (req_addr[1:0] != 2'b00));
`else
   assign w_misalign = 1'b0;
`endif

   // Little-endian lane insert over the word just read.
   always_comb begin
      w_merged = mem_rdata;
      if (r_half) begin
         if (r_lane[1]) w_merged[31:16] = r_data;
         else           w_merged[15:0]  = r_data;
      end else begin
         unique case (r_lane)
            2'd0: w_merged[7:0]   = r_data[7:0];
            2'd1: w_merged[15:8]  = r_data[7:0];
            2'd2: w_merged[23:16] = r_data[7:0];
            2'd3: w_merged[31:24] = r_data[7:0];
            default: w_merged = mem_rdata;
         endcase
      end
   end

   always_comb begin
      w_state     = r_state;
      w_mem_req   = r_mem_req;
      w_mem_we    = r_mem_we;
      w_mem_addr  = r_mem_addr;
      w_mem_wdata = r_mem_wdata;
      w_done      = 1'b0;
      w_err       = 1'b0;
      w_data      = r_data;
      w_half      = r_half;
      w_lane      = r_lane;
      unique case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               w_data     = req_wdata[15:0];
               w_half     = w_is_half;
               w_lane     = req_addr[1:0];
               w_mem_addr = {req_addr[ADDR_W-1:2], 2'b00};
               if (w_misalign) begin
                  w_err = 1'b1;
               end else if (w_is_byte || w_is_half) begin
                  w_state   = ST_READ;
                  w_mem_req = 1'b1;
                  w_mem_we  = 1'b0;
               end else begin
                  w_state     = ST_WRITE;
                  w_mem_req   = 1'b1;
                  w_mem_we    = 1'b1;
                  w_mem_wdata = req_wdata;
               end
            end
         end
         ST_READ: begin
            if (mem_ack) begin
               w_state     = ST_WRITE;
               w_mem_we    = 1'b1;
               w_mem_wdata = w_merged;
            end
         end
         ST_WRITE: begin
            if (mem_ack) begin
               w_state   = ST_IDLE;
               w_mem_req = 1'b0;
               w_mem_we  = 1'b0;
               w_done    = 1'b1;
            end
         end
         default: w_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_data      <= '0;
         r_half      <= 1'b0;
         r_lane      <= '0;
      end else begin
         r_state     <= w_state;
         r_mem_req   <= w_mem_req;
         r_mem_we    <= w_mem_we;
         r_mem_addr  <= w_mem_addr;
         r_mem_wdata <= w_mem_wdata;
         r_done      <= w_done;
         r_err       <= w_err;
         r_data      <= w_data;
         r_half      <= w_half;
         r_lane      <= w_lane;
      end
   end

   assign req_ready = (r_state == ST_IDLE);
   assign done      = r_done;
   assign err       = r_err;
   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_store_rmw_unit.sv
// tb_store_rmw_unit: randomized and directed checks of store_rmw_unit
// against a byte-mask memory model with a configurable-latency memory.
module tb_store_rmw_unit;

   localparam int ADDR_W = 32;
`ifdef MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr = '0;
   logic [31:0]       req_wdata = '0;
   logic [3:0]        ByteControl = 4'hF;
   logic              done;
   logic              err;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata = '0;
   logic              mem_ack = 1'b0;

   always #5 clk = ~clk;

   store_rmw_unit #(.ADDR_W(ADDR_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .ByteControl (ByteControl),
      .done        (done),
      .err         (err),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_ack     (mem_ack)
   );

   bit [31:0] mem     [bit [31:0]];
   bit [31:0] ref_mem [bit [31:0]];

   int          checks = 0;
   int          errors = 0;
   int          ack_delay = 0;
   int          wait_cnt = 0;
   int          n_reads = 0;
   int          n_writes = 0;
   int          n_unstable = 0;
   logic [31:0] last_rd_addr = '0;
   logic [31:0] last_wr_addr = '0;
   logic [31:0] last_wr_data = '0;
   logic [31:0] prev_addr = '0;
   logic        prev_we = 1'b0;

   // Memory: acks after ack_delay waiting cycles, logs each access.
   always @(negedge clk) begin
      if (rst && mem_req) begin
         if (wait_cnt > 0 && (mem_addr !== prev_addr || mem_we !== prev_we))
            n_unstable++;
         prev_addr = mem_addr;
         prev_we   = mem_we;
         if (wait_cnt >= ack_delay) begin
            mem_ack = 1'b1;
            if (mem_we) begin
               mem[mem_addr] = mem_wdata;
               n_writes++;
               last_wr_addr = mem_addr;
               last_wr_data = mem_wdata;
               mem_rdata = $urandom;
            end else begin
               mem_rdata = mem[mem_addr];
               n_reads++;
               last_rd_addr = mem_addr;
            end
            wait_cnt = 0;
         end else begin
            mem_ack = 1'b0;
            mem_rdata = $urandom;
            wait_cnt++;
         end
      end else begin
         mem_ack = 1'b0;
         mem_rdata = $urandom;
         wait_cnt = 0;
      end
   end

   function automatic bit [31:0] model_merge(bit [31:0] old, bit [31:0] a,
                                             bit [31:0] d, bit [3:0] c);
      bit [31:0] mask;
      int        sh;
      if (c == 4'b0001) begin
         sh = 8 * int'(a[1:0]);
         mask = 32'hFF << sh;
      end else if (c == 4'b0011) begin
         sh = a[1] ? 16 : 0;
         mask = 32'hFFFF << sh;
      end else begin
         return d;
      end
      return (old & ~mask) | ((d << sh) & mask);
   endfunction

   function automatic bit model_trap(bit [31:0] a, bit [3:0] c);
      bit mis;
      if (c == 4'b0011)      mis = a[0];
      else if (c == 4'b0001) mis = 1'b0;
      else                   mis = (a[1:0] != 2'b00);
      return TRAP && mis;
   endfunction

   function automatic int model_lat(bit [3:0] c, int d);
      if (c == 4'b0001 || c == 4'b0011) return 3 + 2 * d;
      return 2 + d;
   endfunction

   task automatic preload(input bit [31:0] a, input bit [31:0] v);
      mem[a] = v;
      ref_mem[a] = v;
   endtask

   task automatic clr_log();
      n_reads = 0;
      n_writes = 0;
      n_unstable = 0;
   endtask

   task automatic issue(input bit [31:0] a, input bit [31:0] d,
                        input bit [3:0] c);
      req_addr = a;
      req_wdata = d;
      ByteControl = c;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_addr = $urandom;
      req_wdata = $urandom;
      ByteControl = 4'($urandom);
   endtask

   task automatic wait_done(output int lat, output bit got);
      lat = 1;
      got = 1'b0;
      while (lat < 60) begin
         if (done) begin
            got = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #2;
      checks++;
      if ({req_ready, done, err, mem_req, mem_we} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 10000",
                  {req_ready, done, err, mem_req, mem_we});
      end
      checks++;
      if (mem_addr !== '0 || mem_wdata !== '0) begin
         errors++;
         $display("FAIL reset_bus: got addr %h data %h expected 0 0",
                  mem_addr, mem_wdata);
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic test_word();
      int lat;
      bit got;
      preload(32'h100, 32'h0);
      ref_mem[32'h100] = model_merge(0, 32'h100, 32'hDEADBEEF, 4'hF);
      clr_log();
      ack_delay = 0;
      issue(32'h100, 32'hDEADBEEF, 4'hF);
      wait_done(lat, got);
      checks++;
      if (!got || lat != 2) begin
         errors++;
         $display("FAIL word_latency: got %0d expected 2", got ? lat : -1);
      end
      checks++;
      if (n_reads != 0 || n_writes != 1 || last_wr_addr !== 32'h100 ||
          last_wr_data !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL word_access: got r%0d w%0d %h=%h expected r0 w1 100=deadbeef",
                  n_reads, n_writes, last_wr_addr, last_wr_data);
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL word_done_pulse: got %b expected 0", done);
      end
   endtask

   task automatic test_byte();
      int lat;
      bit got;
      preload(32'h100, 32'h11223344);
      clr_log();
      ack_delay = 0;
      issue(32'h102, 32'h000000AB, 4'b0001);
      wait_done(lat, got);
      checks++;
      if (!got || lat != 3) begin
         errors++;
         $display("FAIL byte_latency: got %0d expected 3", got ? lat : -1);
      end
      checks++;
      if (n_reads != 1 || n_writes != 1 || last_rd_addr !== 32'h100 ||
          last_wr_addr !== 32'h100 || mem[32'h100] !== 32'h11AB3344) begin
         errors++;
         $display("FAIL byte_rmw: got r%0d w%0d mem %h expected r1 w1 11ab3344",
                  n_reads, n_writes, mem[32'h100]);
      end
   endtask

   task automatic test_half_wait();
      int lat;
      bit got;
      preload(32'h104, 32'h11223344);
      clr_log();
      ack_delay = 3;
      issue(32'h106, 32'h0000BEEF, 4'b0011);
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h104) begin
         errors++;
         $display("FAIL half_read_issue: got req %b we %b addr %h expected 1 0 104",
                  mem_req, mem_we, mem_addr);
      end
      wait_done(lat, got);
      checks++;
      if (!got || lat != 9) begin
         errors++;
         $display("FAIL half_latency: got %0d expected 9", got ? lat : -1);
      end
      checks++;
      if (last_wr_addr !== 32'h104 || mem[32'h104] !== 32'hBEEF3344) begin
         errors++;
         $display("FAIL half_data: got %h=%h expected 104=beef3344",
                  last_wr_addr, mem[32'h104]);
      end
      checks++;
      if (n_unstable != 0) begin
         errors++;
         $display("FAIL half_stable: got %0d changes expected 0", n_unstable);
      end
      ack_delay = 0;
   endtask

   task automatic test_misalign();
      int lat;
      bit got;
      preload(32'h100, 32'hAABBCCDD);
      clr_log();
      ack_delay = 0;
      issue(32'h101, 32'h00001234, 4'b0011);
`ifdef MISALIGN_TRAP_EN
      checks++;
      if (err !== 1'b1 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL misalign_trap: got err %b req %b expected 1 0",
                  err, mem_req);
      end
      wait_done(lat, got);
      checks++;
      if (got || n_reads != 0 || n_writes != 0 ||
          mem[32'h100] !== 32'hAABBCCDD) begin
         errors++;
         $display("FAIL misalign_noaccess: got done %b r%0d w%0d mem %h expected 0 0 0 aabbccdd",
                  got, n_reads, n_writes, mem[32'h100]);
      end
`else
      wait_done(lat, got);
      checks++;
      if (!got || err !== 1'b0 || mem[32'h100] !== 32'hAABB1234) begin
         errors++;
         $display("FAIL misalign_half: got done %b err %b mem %h expected 1 0 aabb1234",
                  got, err, mem[32'h100]);
      end
`endif
   endtask

   task automatic test_reset_mid();
      int lat;
      bit got;
      preload(32'h108, 32'h55667788);
      clr_log();
      ack_delay = 20;
      issue(32'h109, 32'h000000CC, 4'b0001);
      @(posedge clk);
      #1;
      checks++;
      if (mem_req !== 1'b1 || req_ready !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_busy: got req %b ready %b expected 1 0",
                  mem_req, req_ready);
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (mem_req !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_drop: got req %b expected 0", mem_req);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      ack_delay = 0;
      @(posedge clk);
      #1;
      checks++;
      if (req_ready !== 1'b1 || n_writes != 0 || done !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_after: got ready %b writes %0d done %b expected 1 0 0",
                  req_ready, n_writes, done);
      end
      ref_mem[32'h108] = model_merge(ref_mem[32'h108], 32'h109, 32'hCC, 4'b0001);
      issue(32'h109, 32'h000000CC, 4'b0001);
      wait_done(lat, got);
      checks++;
      if (!got || lat != 3 || mem[32'h108] !== ref_mem[32'h108]) begin
         errors++;
         $display("FAIL rst_mid_next: got lat %0d mem %h expected 3 %h",
                  got ? lat : -1, mem[32'h108], ref_mem[32'h108]);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      bit got;
      preload(32'h200, 32'h0);
      clr_log();
      ack_delay = 0;
      issue(32'h200, 32'h11, 4'b0001);
      wait_done(lat, got);
      checks++;
      if (!got || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_first: got done %b ready %b expected 1 1",
                  got, req_ready);
      end
      issue(32'h201, 32'h22, 4'b0001);
      checks++;
      if (req_ready !== 1'b0 || mem_req !== 1'b1) begin
         errors++;
         $display("FAIL b2b_accept: got ready %b req %b expected 0 1",
                  req_ready, mem_req);
      end
      wait_done(lat, got);
      checks++;
      if (!got || lat != 3 || mem[32'h200] !== 32'h00002211) begin
         errors++;
         $display("FAIL b2b_final: got lat %0d mem %h expected 3 00002211",
                  got ? lat : -1, mem[32'h200]);
      end
   endtask

   task automatic test_random();
      int          lat;
      int          d;
      bit          got;
      bit [31:0]   a;
      bit [31:0]   data;
      bit [31:0]   wa;
      bit [3:0]    c;
      bit [3:0]    codes [4];
      codes[0] = 4'b0001;
      codes[1] = 4'b0011;
      codes[2] = 4'b1111;
      for (int i = 0; i < 4; i++) preload(32'h300 + 4 * i, $urandom);
      for (int n = 0; n < 40; n++) begin
         codes[3] = 4'($urandom);
         a = 32'h300 + $urandom_range(0, 15);
         data = $urandom;
         c = codes[$urandom_range(0, 3)];
         d = $urandom_range(0, 2);
         wa = {a[31:2], 2'b00};
         ack_delay = d;
         if (model_trap(a, c)) begin
            issue(a, data, c);
            checks++;
            if (err !== 1'b1 || mem_req !== 1'b0) begin
               errors++;
               $display("FAIL rand_trap[%0d]: got err %b req %b expected 1 0",
                        n, err, mem_req);
            end
            @(posedge clk);
            #1;
         end else begin
            ref_mem[wa] = model_merge(ref_mem[wa], a, data, c);
            issue(a, data, c);
            wait_done(lat, got);
            checks++;
            if (!got || lat != model_lat(c, d)) begin
               errors++;
               $display("FAIL rand_lat[%0d]: got %0d expected %0d",
                        n, got ? lat : -1, model_lat(c, d));
            end
         end
         checks++;
         if (mem[wa] !== ref_mem[wa]) begin
            errors++;
            $display("FAIL rand_mem[%0d]: got %h expected %h (a=%h c=%b)",
                     n, mem[wa], ref_mem[wa], a, c);
         end
      end
      ack_delay = 0;
   endtask

   initial begin
      test_reset();
      test_word();
      test_byte();
      test_half_wait();
      test_misalign();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
